// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : div_pkg
//  Purpose : Shared definitions for the radix-2 restoring divider: FSM state
//            encoding, operand width, result latency and a magnitude helper.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_W   = 32;  // operand width
    localparam int DIV_LAT = 34;  // cycles from second capture to result valid

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Magnitude of a value; negative two's-complement inputs are negated only
    // when signed interpretation is requested. 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [DIV_W-1:0] f_mag(input logic [DIV_W-1:0] v,
                                               input logic             is_signed);
        return (is_signed && v[DIV_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module  : div_step
//  Purpose : One restoring shift-compare-subtract step (combinational).
//  Ports   : rem_in  - partial remainder before the step
//            dvd_bit - next dividend bit shifted in (MSB first)
//            divisor - divisor magnitude
//            rem_out - partial remainder after the step
//            q_bit   - quotient bit produced by this step
//  Revision: 1.0 - initial release
// ============================================================================
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] rem_out,
    output logic             q_bit
);

    // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
    logic [DIV_W:0] w_shift;
    logic [DIV_W:0] w_diff;

    assign w_shift = {rem_in, dvd_bit};
    assign w_diff  = w_shift - {1'b0, divisor};
    assign q_bit   = (w_shift >= {1'b0, divisor});
    // When no subtraction happens the shifted value is below the divisor, so
    // its top bit is zero and truncation is lossless.
    assign rem_out = q_bit ? w_diff[DIV_W-1:0] : w_shift[DIV_W-1:0];

endmodule
`default_nettype wire

// File: rtl/radix2_div.sv
`default_nettype none
// ============================================================================
//  Module  : radix2_div
//  Purpose : Iterative radix-2 restoring divider, 32-bit operands, signed or
//            unsigned. Two independent AXI-stream-like operand slots; the
//            result appears DIV_LAT cycles after the second operand is taken.
//  Ports   : clk, reset (sync, active-high)
//            s_axis_dividend_{tdata,tvalid,tready} - dividend slot
//            s_axis_divisor_{tdata,tvalid,tready}  - divisor slot
//            m_axis_dout_tdata  - {remainder, quotient}
//            m_axis_dout_tvalid - one-cycle result strobe (no back-pressure)
//  Revision: 1.0 - initial release
// ============================================================================
module radix2_div
    import div_pkg::*;
#(
    parameter int SIGNED = 1,
    parameter int WIDTH  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata,
    output logic               m_axis_dout_tvalid
);

    localparam logic C_SIGNED = (SIGNED != 0);

    state_e             r_state;
    logic               r_dvd_got;
    logic               r_dvs_got;
    logic [DIV_W-1:0]   r_dvd;
    logic [DIV_W-1:0]   r_dvs;
    logic [DIV_W-1:0]   r_quo;
    logic [DIV_W-1:0]   r_rem;
    logic [5:0]         r_cnt;
    logic [2*DIV_W-1:0] r_dout;

    logic               w_dvd_hs;
    logic               w_dvs_hs;
    logic [DIV_W-1:0]   w_dvd_mag;
    logic [DIV_W-1:0]   w_dvs_mag;
    logic [4:0]         w_bit_idx;
    logic [DIV_W-1:0]   w_rem_nxt;
    logic               w_q_bit;
    logic [DIV_W-1:0]   w_quo_fix;
    logic [DIV_W-1:0]   w_rem_fix;

    // ------------------------------------------------------------------
    // Handshakes: each slot is open only in IDLE until its operand lands.
    // ------------------------------------------------------------------
    assign s_axis_dividend_tready = !reset && (r_state == ST_IDLE) && !r_dvd_got;
    assign s_axis_divisor_tready  = !reset && (r_state == ST_IDLE) && !r_dvs_got;

    assign w_dvd_hs = s_axis_dividend_tvalid && s_axis_dividend_tready;
    assign w_dvs_hs = s_axis_divisor_tvalid  && s_axis_divisor_tready;

    // ------------------------------------------------------------------
    // Datapath: captured raw operands stay intact through CALC so FIX can
    // recover the signs and the divide-by-zero pass-through value.
    // ------------------------------------------------------------------
    assign w_dvd_mag = f_mag(r_dvd, C_SIGNED);
    assign w_dvs_mag = f_mag(r_dvs, C_SIGNED);
    assign w_bit_idx = 5'(DIV_W - 1) - r_cnt[4:0];

    div_step u_step (
        .rem_in  (r_rem),
        .dvd_bit (w_dvd_mag[w_bit_idx]),
        .divisor (w_dvs_mag),
        .rem_out (w_rem_nxt),
        .q_bit   (w_q_bit)
    );

    // Sign restoration; divide-by-zero bypasses it so the result is the
    // same all-ones quotient and raw dividend in both modes.
    always_comb begin
        w_quo_fix = r_quo;
        w_rem_fix = r_rem;
        if (r_dvs == '0) begin
            w_quo_fix = '1;
            w_rem_fix = r_dvd;
        end else if (C_SIGNED) begin
            if (r_dvd[DIV_W-1] ^ r_dvs[DIV_W-1]) begin
                w_quo_fix = ~r_quo + 1'b1;
            end
            if (r_dvd[DIV_W-1]) begin
                w_rem_fix = ~r_rem + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_dvd_got <= 1'b0;
            r_dvs_got <= 1'b0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_dout    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_dvd_hs) begin
                        r_dvd     <= s_axis_dividend_tdata;
                        r_dvd_got <= 1'b1;
                    end
                    if (w_dvs_hs) begin
                        r_dvs     <= s_axis_divisor_tdata;
                        r_dvs_got <= 1'b1;
                    end
                    if ((r_dvd_got || w_dvd_hs) && (r_dvs_got || w_dvs_hs)) begin
                        r_state   <= ST_CALC;
                        r_dvd_got <= 1'b0;
                        r_dvs_got <= 1'b0;
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quo     <= '0;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= {r_quo[DIV_W-2:0], w_q_bit};
                    if (r_cnt == 6'(DIV_W - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                ST_FIX: begin
                    r_dout  <= {w_rem_fix, w_quo_fix};
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_dout_tvalid = !reset && (r_state == ST_DONE);
    assign m_axis_dout_tdata  = reset ? '0 : r_dout;

endmodule
`default_nettype wire
